// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder family: FSM encoding and a
// counter-width helper sized at elaboration time.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..value-1; value must be at least 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the serial datapath reuses this single cell every cycle.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one bit per clock, LSB first, result registered
// and flagged by a one-cycle Done pulse after WIDTH clocks.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               bit_s;
    logic               bit_co;
    logic               last_bit;

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Subtraction is folded in at load time (B inverted, carry-in inverted),
    // so the RUN datapath never needs to know the operation.
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain the shift stages in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Sum    <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sr   <= A;
                        b_sr   <= Sub ? ~B : B;
                        carry  <= Sub ? ~Cin : Cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    carry  <= bit_co;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        Sum   <= {bit_s, res_sr[WIDTH-1:1]};
                        Cout  <= bit_co;
                        Ovf   <= carry ^ bit_co;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): stimulus pushes expected results
// into a queue, a monitor pops and compares on every Done pulse.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    // expected {Sum, Cout, Ovf}
    logic [W+1:0] exp_q[$];
    int checks;
    int failures;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(Done), 32'd0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("result_sum", 32'(Sum), 32'(e[W+1:2]));
                check("result_cout", 32'(Cout), 32'(e[1]));
                check("result_ovf", 32'(Ovf), 32'(e[0]));
            end
        end
    end

    // Present one operation; the start edge is consumed before returning.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin,
                            input logic push, input logic [W+1:0] exp);
        @(negedge clk);
        A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1 Start = 1'b0;
    endtask

    // Called #1 after the start edge; returns edges counted until Done,
    // checking Busy stays high throughout and Sum holds prev_sum mid-run.
    task automatic wait_done(input string name, input logic [W-1:0] prev_sum);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        while (Done !== 1'b1 && lat < 20) begin
            if (Busy === 1'b1) busy_cycles++;
            if (lat == 4) check({name, "_sum_held"}, 32'(Sum), 32'(prev_sum));
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        check({name, "_busy_low_at_done"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_sum", 32'(Sum), 32'd0);
        check("reset_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 0F + 01 = 10
        start_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, {8'h10, 1'b0, 1'b0});
        wait_done("add_basic", 8'h00);
        // FF + 01 + 1 = 101
        start_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, {8'h01, 1'b1, 1'b0});
        wait_done("add_carry", 8'h10);
        // 7F + 01 = 80, signed overflow
        start_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
        wait_done("add_ovf", 8'h01);
        // 05 - 07 = FE, borrow
        start_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0});
        wait_done("sub_borrow", 8'h80);
        // 10 - 01 - 1 = 0E, no borrow
        start_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b1, {8'h0E, 1'b1, 1'b0});
        wait_done("sub_borrow_in", 8'hFE);

        // 3C + 21 = 5D; re-Start and operand churn mid-run must be ignored
        start_op(8'h3C, 8'h21, 1'b0, 1'b0, 1'b1, {8'h5D, 1'b0, 1'b0});
        @(posedge clk);
        #1 A = 8'hAA; B = 8'h55; Sub = 1'b1; Cin = 1'b1; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        begin
            int lat;
            lat = 2;
            while (Done !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("restart_ignored_latency", 32'(lat), 32'd8);
        end
        // Back-to-back start on the Done cycle: 80 - 01 = 7F, overflow
        A = 8'h80; B = 8'h01; Sub = 1'b1; Cin = 1'b0; Start = 1'b1;
        exp_q.push_back({8'h7F, 1'b1, 1'b1});
        @(posedge clk);
        #1 Start = 1'b0;
        check("b2b_accepted_busy", 32'(Busy), 32'd1);
        wait_done("b2b", 8'h5D);

        // Asynchronous reset mid-operation aborts with no Done
        start_op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
        Start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_start_during_reset", 32'(Busy), 32'd0);
        check("no_done_after_abort", 32'(exp_q.size()), 32'd0);

        // First operation after reset release
        start_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, {8'h07, 1'b0, 1'b0});
        wait_done("post_reset", 8'h00);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the operand and result width in bits; legal values are 2..32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-004 Port Start, input, 1 bit: request to begin an operation.
REQ-005 Port Sub, input, 1 bit: 0 = add, 1 = subtract; sampled with Start.
REQ-006 Port A, input, WIDTH bits: first operand; sampled with Start.
REQ-007 Port B, input, WIDTH bits: second operand; sampled with Start.
REQ-008 Port Cin, input, 1 bit: carry-in (add) or borrow-in (subtract); sampled with Start.
REQ-009 Port Busy, output, 1 bit: an operation is in progress.
REQ-010 Port Done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 Port Sum, output, WIDTH bits: registered result.
REQ-012 Port Cout, output, 1 bit: registered final carry.
REQ-013 Port Ovf, output, 1 bit: registered signed (two's-complement) overflow.

Function
REQ-014 FSM states SHALL be IDLE and RUN; Done is a separate registered flag.
REQ-015 IDLE to RUN: at a rising edge with Start=1 and Busy=0, the block SHALL load A, B, Sub and Cin into internal shift registers, clear the bit counter and set Busy=1.
REQ-016 Start at Busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-017 In RUN, each rising edge SHALL process exactly one bit, LSB first; bit i is resolved on the (i+1)th edge after the Start edge.
REQ-018 Add (Sub=0): result = A + B + Cin; the initial carry is Cin.
REQ-019 Subtract (Sub=1): result = A - B - Cin, computed as A + ~B with initial carry ~Cin.
REQ-020 Result width SHALL be WIDTH mod 2^WIDTH; Cout SHALL be the carry out of the MSB. In subtract, Cout=1 means no borrow.
REQ-021 Ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 On the WIDTH-th edge after the Start edge, the block SHALL:
  - update Sum, Cout and Ovf together;
  - clear Busy and return to IDLE;
  - set Done=1 for exactly one cycle.
REQ-023 Sum, Cout and Ovf SHALL hold their last completed result, unchanged while a new operation runs, until that operation completes.
REQ-024 Latency from the Start edge to Done=1 SHALL be WIDTH cycles; throughput is one operation per WIDTH cycles.
REQ-025 Start=1 in the cycle where Done=1 (Busy=0) SHALL be accepted, allowing back-to-back operations with no idle cycle.
REQ-026 Operand changes on A, B, Sub and Cin while Busy=1 SHALL NOT affect the result.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE;
  - Busy, Done, Sum, Cout and Ovf to 0;
  - the counter and shift registers to 0.
REQ-028 rst asserted mid-operation SHALL abort the operation; no Done pulse is produced for it.
REQ-029 Start SHALL be ignored while rst=1; the first Start after reset release SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings (IDLE, RUN) and the counter-width function clog2, for reuse by later adder variants.
REQ-031 The per-bit logic SHALL be a combinational sub-module fa_cell (inputs a, b, ci; outputs s, co), instantiated once.
REQ-032 The parent module SHALL contain the FSM, the counter, the shift registers and the output registers.

Verification (WIDTH=8)
REQ-033 A=8'h0F, B=8'h01, Sub=0, Cin=0, Start pulse -> 8 cycles later Done=1 with Sum=8'h10, Cout=0, Ovf=0; Busy high during exactly those 8 cycles.
REQ-034 A=8'hFF, B=8'h01, Cin=1, add -> Sum=8'h01, Cout=1, Ovf=0.
REQ-035 A=8'h7F, B=8'h01, Cin=0, add -> Sum=8'h80, Cout=0, Ovf=1.
REQ-036 A=8'h05, B=8'h07, Cin=0, Sub=1 -> Sum=8'hFE, Cout=0, Ovf=0.
REQ-037 Start re-pulsed at cycle 3 of an operation -> ignored and the result unchanged; Start on the Done cycle -> second result after exactly 8 more cycles.
REQ-038 rst pulsed asynchronously at cycle 4 of an operation -> Busy, Done, Sum, Cout and Ovf all 0 immediately; no Done follows; a next operation 8'h03+8'h04 gives Sum=8'h07.
